// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder.
// Holds the slice width and the three-state controller encoding.
`timescale 1ns/1ps
package cla_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : cla_pkg

// File: rtl/cla_block.sv
// 4-bit carry-lookahead slice: nibble sum plus group generate/propagate.
// The group outputs let the caller form the slice carry-out externally.
`timescale 1ns/1ps
module cla_block
    import cla_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                gg_o,
    output logic                pg_o
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] c;

    // Per-bit generate/propagate and flat lookahead carries into each bit.
    always_comb begin
        g     = a_i & b_i;
        p     = a_i ^ b_i;
        c[0]  = cin_i;
        c[1]  = g[0] | (p[0] & cin_i);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin_i);
        sum_o = p ^ c;
        gg_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        pg_o  = &p;
    end

endmodule : cla_block

// File: rtl/cla_seq_adder.sv
// Sequential WIDTH-bit adder: one shared 4-bit CLA slice walks the operands
// one nibble per clock, LSB first, with a ready/valid handshake on each side.
// Optional feature macro: SEQ_ADD_SUB_EN adds the 'sub' port (a - b).
// WIDTH must be a multiple of 4 and at least 8.
`timescale 1ns/1ps
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SEQ_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int                NIB_N    = WIDTH / NIBBLE_W;
    localparam int                IDX_W    = $clog2(NIB_N);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIB_N - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_out_q, carry_out_d;
`ifdef SEQ_ADD_SUB_EN
    logic               sub_q, sub_d;
`endif

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_gg;
    logic                slice_pg;
    logic                next_carry;

    // Select the current operand nibbles (b inverted when subtracting).
    always_comb begin
        slice_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
`ifdef SEQ_ADD_SUB_EN
        slice_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
`else
        slice_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
`endif
        next_carry = slice_gg | (slice_pg & carry_q);
    end

    cla_block u_slice (
        .a_i   (slice_a),
        .b_i   (slice_b),
        .cin_i (carry_q),
        .sum_o (slice_sum),
        .gg_o  (slice_gg),
        .pg_o  (slice_pg)
    );

    // Controller next-state, datapath next-values and handshake outputs.
    always_comb begin
        // NOTE: every signal gets its hold/default value first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
`ifdef SEQ_ADD_SUB_EN
        sub_d       = sub_q;
`endif
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
`ifdef SEQ_ADD_SUB_EN
                    sub_d   = sub;
                    carry_d = sub;
`else
                    carry_d = 1'b0;
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_sum;
                carry_d = next_carry;
                if (idx_q == LAST_IDX) begin
                    carry_out_d = next_carry;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
`ifdef SEQ_ADD_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
`ifdef SEQ_ADD_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;

endmodule : cla_seq_adder

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (WIDTH=32); subtraction vectors are
// exercised only when SEQ_ADD_SUB_EN is defined.
`timescale 1ns/1ps
module tb_cla_seq_adder;

    localparam int WIDTH = 32;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic             sub       = 1'b0;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SEQ_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for out_valid; lat counts edges since the accepting edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // One complete operation with out_ready held high; starts in IDLE.
    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [31:0] es, input logic eco);
        int lat;
        a        = x;
        b        = y;
        sub      = s;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_busy_in_ready"}, 64'(in_ready), 64'(0));
        wait_valid(lat);
        check({tag, "_latency"}, 64'(lat), 64'(8));
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_carry_out"}, 64'(carry_out), 64'(eco));
        step();
        check({tag, "_idle_in_ready"}, 64'(in_ready), 64'(1));
        check({tag, "_idle_out_valid"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        int lat;
        int acc_cyc[3];
        logic [31:0] bb_a[3];
        logic [31:0] bb_b[3];
        logic [31:0] bb_s[3];
        logic        bb_c[3];

        // Reset state
        #2;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_carry_out", 64'(carry_out), 64'(0));
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Accept on the first edge after reset release; simple nibble carry
        run_op("f_plus_1", 32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0);
        // Full carry ripple through all eight nibbles
        run_op("ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
        // All-propagate, no generate anywhere
        run_op("all_prop", 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 32'hFFFFFFFF, 1'b0);
        // MSB-only overflow
        run_op("msb_ovf", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1);

        // Backpressure: result held while out_ready is low; inputs ignored
        out_ready = 1'b0;
        a        = 32'h12345678;
        b        = 32'h11111111;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(lat);
        check("hold_latency", 64'(lat), 64'(8));
        for (int i = 0; i < 5; i++) begin
            check("hold_sum", 64'(sum), 64'(32'h23456789));
            check("hold_carry_out", 64'(carry_out), 64'(0));
            check("hold_in_ready", 64'(in_ready), 64'(0));
            check("hold_out_valid", 64'(out_valid), 64'(1));
            in_valid = 1'b1;
            a        = 32'hDEADBEEF;
            b        = 32'hCAFEF00D;
            step();
        end
        in_valid  = 1'b0;
        check("hold_end_sum", 64'(sum), 64'(32'h23456789));
        out_ready = 1'b1;
        step();
        check("hold_release_in_ready", 64'(in_ready), 64'(1));
        check("hold_release_out_valid", 64'(out_valid), 64'(0));

        // Asynchronous reset in the middle of BUSY
        a        = 32'h00001111;
        b        = 32'h00002222;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_sum", 64'(sum), 64'(0));
        check("midrst_carry_out", 64'(carry_out), 64'(0));
        step();
        rst_n = 1'b1;
        run_op("after_rst", 32'd2, 32'd3, 1'b0, 32'd5, 1'b0);

`ifdef SEQ_ADD_SUB_EN
        run_op("sub_5_7", 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0);
        run_op("sub_7_5", 32'd7, 32'd5, 1'b1, 32'd2, 1'b1);
        run_op("add_after_sub", 32'd7, 32'd5, 1'b0, 32'd12, 1'b0);
`endif

        // Back-to-back with in_valid and out_ready both held high
        bb_a[0] = 32'h00000100; bb_b[0] = 32'h00000023; bb_s[0] = 32'h00000123; bb_c[0] = 1'b0;
        bb_a[1] = 32'hAAAAAAAA; bb_b[1] = 32'h55555556; bb_s[1] = 32'h00000000; bb_c[1] = 1'b1;
        bb_a[2] = 32'h7FFFFFFF; bb_b[2] = 32'h00000001; bb_s[2] = 32'h80000000; bb_c[2] = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = bb_a[k];
            b = bb_b[k];
            step();
            acc_cyc[k] = cyc;
            check("b2b_accepted", 64'(in_ready), 64'(0));
            if (k > 0) begin
                check("b2b_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(10));
            end
            wait_valid(lat);
            check("b2b_latency", 64'(lat), 64'(8));
            check("b2b_sum", 64'(sum), 64'(bb_s[k]));
            check("b2b_carry_out", 64'(carry_out), 64'(bb_c[k]));
            step();
            check("b2b_idle", 64'(in_ready), 64'(1));
        end
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cla_seq_adder
